// File: rtl/ldpc_flood_sched_pkg.sv
// Shared constants and state encoding for the flooding-schedule LDPC decoder sequencer.
package ldpc_flood_sched_pkg;

  localparam int unsigned code_n            = 204;
  localparam int unsigned code_m            = 102;
  localparam int unsigned code_log2n        = 8;
  localparam int unsigned code_log2m        = 7;
  localparam int unsigned code_max_iter     = 30;
  localparam int unsigned code_log2max_iter = 5;

  localparam int unsigned msg_int_w  = 4;
  localparam int unsigned msg_frac_w = 2;
  localparam int unsigned msg_w      = msg_int_w + msg_frac_w;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CN       = 3'd2,
    CN_DRAIN = 3'd3,
    VN       = 3'd4,
    VN_DRAIN = 3'd5,
    FIN      = 3'd6
  } state_e;

  function automatic logic in_cn_phase(state_e s);
    return (s == CN) || (s == CN_DRAIN);
  endfunction

  function automatic logic in_vn_phase(state_e s);
    return (s == VN) || (s == VN_DRAIN);
  endfunction

endpackage

// File: rtl/ldpc_flood_sched_if.sv
// Control bundle between the LDPC sequencer (master) and the decoder datapath (slave).
interface ldpc_flood_sched_if
  import ldpc_flood_sched_pkg::*;
#(
  parameter int unsigned log2n        = code_log2n,
  parameter int unsigned log2m        = code_log2m,
  parameter int unsigned log2max_iter = code_log2max_iter
);

  logic                    start;
  logic                    stall;
  logic                    busy;
  logic [log2n-1:0]        v_rd_addr;
  logic [log2m-1:0]        c_rd_addr;
  logic                    v_wr;
  logic [log2n-1:0]        v_wr_addr;
  logic                    c_wr;
  logic [log2m-1:0]        c_wr_addr;
  logic                    llr_sel;
  logic                    syn_in;
  logic                    done;
  logic                    success;
  logic [log2max_iter-1:0] iterations;

  modport master (
    input  start, stall, syn_in,
    output busy, v_rd_addr, c_rd_addr, v_wr, v_wr_addr, c_wr, c_wr_addr,
    output llr_sel, done, success, iterations
  );

  modport slave (
    output start, stall, syn_in,
    input  busy, v_rd_addr, c_rd_addr, v_wr, v_wr_addr, c_wr, c_wr_addr,
    input  llr_sel, done, success, iterations
  );

endinterface

// File: rtl/ldpc_flood_sched_wb_pipe.sv
// Valid+address delay line matching the BRAM read latency; the whole line freezes on stall.
module ldpc_flood_sched_wb_pipe #(
  parameter int unsigned depth  = 2,
  parameter int unsigned addr_w = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [addr_w-1:0] in_addr,
  output logic              out_valid,
  output logic [addr_w-1:0] out_addr,
  output logic              pending
);

  logic [depth-1:0]             valid_q;
  logic [depth-1:0][addr_w-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int unsigned i = 1; i < depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[depth-1];
  assign out_addr  = addr_q[depth-1];

  // Entries still in flight behind the exit stage; clear means the exit is the last one.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < depth; i++) begin
      pending = pending | valid_q[i];
    end
  end

endmodule

// File: rtl/ldpc_flood_sched.sv
// Flooding-schedule LDPC sequencer: LLR load, CN pass with syndrome check, VN pass, iterate.
module ldpc_flood_sched
  import ldpc_flood_sched_pkg::*;
#(
  parameter int unsigned n            = code_n,
  parameter int unsigned m            = code_m,
  parameter int unsigned log2n        = code_log2n,
  parameter int unsigned log2m        = code_log2m,
  parameter int unsigned max_iter     = code_max_iter,
  parameter int unsigned log2max_iter = code_log2max_iter,
  parameter int unsigned READ_LAT     = 2
) (
  input logic               clk,
  input logic               rst_n,
  ldpc_flood_sched_if.master bus
);

  state_e                  state_q;
  logic [log2n-1:0]        load_cnt_q;
  logic [log2n-1:0]        v_rd_addr_q;
  logic [log2m-1:0]        c_rd_addr_q;
  logic [log2max_iter-1:0] iter_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    success_q;
  logic                    syn_acc_q;

  logic             issue_valid;
  logic [log2n-1:0] issue_addr;
  logic             wb_valid;
  logic [log2n-1:0] wb_addr;
  logic             wb_pending;
  logic             wb_fire;
  logic             c_wr;
  logic             v_wr;
  logic             load_wr;
  logic             drain_done;
  logic             syn_now;

  // CN and VN share the pipe; they never overlap because each pass drains before the next.
  assign issue_valid = (state_q == CN) || (state_q == VN);
  assign issue_addr  = (state_q == CN) ? log2n'(c_rd_addr_q) : v_rd_addr_q;

  ldpc_flood_sched_wb_pipe #(
    .depth  (READ_LAT),
    .addr_w (log2n)
  ) u_wb_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (bus.stall),
    .in_valid  (issue_valid),
    .in_addr   (issue_addr),
    .out_valid (wb_valid),
    .out_addr  (wb_addr),
    .pending   (wb_pending)
  );

  assign wb_fire    = wb_valid && !bus.stall;
  assign load_wr    = (state_q == LOAD) && !bus.stall;
  assign c_wr       = wb_fire && in_cn_phase(state_q);
  assign v_wr       = load_wr || (wb_fire && in_vn_phase(state_q));
  assign drain_done = !bus.stall && !wb_pending;
  // Include the row written this cycle so the drain decision sees the final syndrome bit.
  assign syn_now    = syn_acc_q || (c_wr && bus.syn_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      v_rd_addr_q <= '0;
      c_rd_addr_q <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      syn_acc_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      syn_acc_q <= syn_now;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            success_q  <= 1'b0;
            iter_q     <= '0;
            syn_acc_q  <= 1'b0;
            load_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (!bus.stall) begin
            if (load_cnt_q == log2n'(n - 1)) begin
              state_q     <= CN;
              c_rd_addr_q <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + log2n'(1);
            end
          end
        end
        CN: begin
          if (!bus.stall) begin
            if (c_rd_addr_q == log2m'(m - 1)) begin
              state_q <= CN_DRAIN;
            end else begin
              c_rd_addr_q <= c_rd_addr_q + log2m'(1);
            end
          end
        end
        CN_DRAIN: begin
          if (drain_done) begin
            if (!syn_now) begin
              state_q   <= FIN;
              success_q <= 1'b1;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
            end else if (iter_q == log2max_iter'(max_iter)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= VN;
              v_rd_addr_q <= '0;
            end
          end
        end
        VN: begin
          if (!bus.stall) begin
            if (v_rd_addr_q == log2n'(n - 1)) begin
              state_q <= VN_DRAIN;
            end else begin
              v_rd_addr_q <= v_rd_addr_q + log2n'(1);
            end
          end
        end
        VN_DRAIN: begin
          if (drain_done) begin
            state_q     <= CN;
            iter_q      <= iter_q + log2max_iter'(1);
            syn_acc_q   <= 1'b0;
            c_rd_addr_q <= '0;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.success    = success_q;
  assign bus.iterations = iter_q;
  assign bus.v_rd_addr  = v_rd_addr_q;
  assign bus.c_rd_addr  = c_rd_addr_q;
  assign bus.llr_sel    = (state_q == LOAD);
  assign bus.v_wr       = v_wr;
  assign bus.c_wr       = c_wr;
  assign bus.v_wr_addr  = (state_q == LOAD) ? load_cnt_q : wb_addr;
  assign bus.c_wr_addr  = wb_addr[log2m-1:0];

  a_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(c_wr && v_wr));
  a_done_pulse:   assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule

// File: doc/ldpc_flood_sched.md
Name: ldpc_flood_sched

Overview:
- Sequencer for the flooding-schedule LDPC decoder datapath (check-node unit, variable-node unit, v_msg/c_msg message BRAMs, neighbour-table BRAMs).
- Issues BRAM read addresses and delayed write-back strobes for each phase: channel-LLR load, check-node pass with syndrome accumulation, variable-node pass.
- Counts iterations and stops on an all-zero syndrome or at max_iter.
- Lets the datapath be pure pipeline with no FSM of its own.

Parameters:
- n, 204, number of variable nodes.
- m, 102, number of check nodes.
- log2n, 8, width of variable-node addresses.
- log2m, 7, width of check-node addresses.
- max_iter, 30, maximum decoding iterations.
- log2max_iter, 5, width of the iteration counter.
- READ_LAT, 2, cycles from address issue to write-back (1 BRAM read + 1 operand register); must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a decode; sampled only in IDLE.
- stall  in  1  freezes address issue and the whole write-back pipeline while high.
- busy  out  1  high from the cycle after start is accepted until done.
- v_rd_addr  out  log2n  v_msg / v_neighbor / neighbor_index_to_ch read address.
- c_rd_addr  out  log2m  c_msg / c_neighbor / neighbor_index_to_var read address.
- v_wr  out  1  v_msg write enable.
- v_wr_addr  out  log2n  v_msg write address.
- c_wr  out  1  c_msg write enable.
- c_wr_addr  out  log2m  c_msg write address.
- llr_sel  out  1  high in LOAD: v_msg data is the channel-LLR replica.
- syn_in  in  1  parity of the current check row's hard bits; valid when c_wr is high.
- done  out  1  one-cycle pulse at the end of a decode.
- success  out  1  syndrome was zero at termination; held until the next start.
- iterations  out  log2max_iter  number of VN passes completed; held until the next start.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; counters and the pipeline shift register cleared. Reset mid-decode aborts immediately; no done pulse.
- States: IDLE, LOAD, CN, CN_DRAIN, VN, VN_DRAIN, FIN.
- IDLE: start=1 moves to LOAD next cycle. That cycle clears success, iterations and syn_acc, and sets busy=1. start is ignored in every other state.
- LOAD:
  - v_wr=1, llr_sel=1, v_wr_addr = 0..n-1, one per unstalled cycle. No read latency applies.
  - After address n-1, go to CN.
- CN:
  - c_rd_addr = 0..m-1, one per unstalled cycle.
  - Each issued address enters a READ_LAT-deep valid/address pipe. On exit it drives c_wr=1 with c_wr_addr equal to the issued address.
  - When c_wr=1, syn_acc |= syn_in.
  - After issuing m-1, go to CN_DRAIN.
- CN_DRAIN: wait until the pipe is empty (READ_LAT cycles if unstalled), then decide. If syn_acc=0, go to FIN with success=1. Else if iterations==max_iter, go to FIN with success=0. Else go to VN.
- VN: v_rd_addr = 0..n-1 through the same pipe; exit drives v_wr=1 with v_wr_addr. After issuing n-1, go to VN_DRAIN.
- VN_DRAIN: when the pipe is empty, iterations += 1, syn_acc cleared, go to CN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- The first CN pass after LOAD doubles as the initial hard-decision syndrome check. Its c_msg writes are real messages.
- Stall: counters, pipe contents and state hold. Write enables are forced to 0 during stall and reassert on resume with the same address. No address is skipped or duplicated.
- Read addresses hold their last value outside CN/VN. c_wr and v_wr are never both high. c_wr_addr/v_wr_addr are valid only when the matching enable is high.
- Unstalled cycle count:
  - clean first syndrome: n + m + READ_LAT + 1;
  - each further iteration: n + m + 2·READ_LAT.

Decomposition:
- Shared package ldpc_pkg holds:
  - code constants n, m, log2n, log2m, max_iter;
  - INT/FRAC message widths;
  - the state encoding (localparams IDLE=0 … FIN=6).
- One natural sub-module: ldpc_wb_pipe, a READ_LAT-deep valid+address shift register with hold (stall). It is instantiated once and shared by CN and VN, with address width log2n.

Test Plan:
- All shared setup: n=12, m=6, READ_LAT=2, max_iter=3.
- Clean codeword: start with syn_in=0 always → 12 v_wr (addr 0..11), then 6 c_wr (addr 0..5). done at cycle 12+6+2+1=21 after start; success=1, iterations=0, no VN writes.
- Never-clean syndrome: syn_in=1 on every c_wr → 4 CN passes and 3 VN passes. done with success=0, iterations=3. v_wr count = 12 + 3·12 = 48; c_wr count = 24.
- Converges in iteration 2: syn_in=1 on CN passes 0–1, 0 on pass 2 → success=1, iterations=2.
- Stall mid-CN: assert stall for 3 cycles when c_rd_addr=3 → c_wr sequence is still exactly 0..5 with no gaps or duplicates. done is delayed by 3 cycles.
- Reset abort: drop rst_n in VN at v_rd_addr=7 → next cycle all outputs 0, state IDLE. A new start decodes normally.
- start held high through the whole decode → only one decode runs. A new decode starts only if start is still high in IDLE after FIN.
